// File: rtl/mrmac_ddr_wr_arb.sv
// Two-requester AXI write arbiter feeding a single DDR write port.
// Whole bursts are granted round-robin, W beats are never interleaved,
// and B responses are routed back by the MSB of the DDR-side ID.
module mrmac_ddr_wr_arb #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 512,
    parameter int unsigned ID_WIDTH        = 4,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [ID_WIDTH-1:0]       s0_axi_awid,
    input  logic [ADDR_WIDTH-1:0]     s0_axi_awaddr,
    input  logic [7:0]                s0_axi_awlen,
    input  logic [2:0]                s0_axi_awsize,
    input  logic [1:0]                s0_axi_awburst,
    input  logic                      s0_axi_awvalid,
    output logic                      s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s0_axi_wstrb,
    input  logic                      s0_axi_wlast,
    input  logic                      s0_axi_wvalid,
    output logic                      s0_axi_wready,
    output logic [ID_WIDTH-1:0]       s0_axi_bid,
    output logic [1:0]                s0_axi_bresp,
    output logic                      s0_axi_bvalid,
    input  logic                      s0_axi_bready,

    input  logic [ID_WIDTH-1:0]       s1_axi_awid,
    input  logic [ADDR_WIDTH-1:0]     s1_axi_awaddr,
    input  logic [7:0]                s1_axi_awlen,
    input  logic [2:0]                s1_axi_awsize,
    input  logic [1:0]                s1_axi_awburst,
    input  logic                      s1_axi_awvalid,
    output logic                      s1_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s1_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s1_axi_wstrb,
    input  logic                      s1_axi_wlast,
    input  logic                      s1_axi_wvalid,
    output logic                      s1_axi_wready,
    output logic [ID_WIDTH-1:0]       s1_axi_bid,
    output logic [1:0]                s1_axi_bresp,
    output logic                      s1_axi_bvalid,
    input  logic                      s1_axi_bready,

    output logic [ID_WIDTH:0]         m_axi_awid,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [ID_WIDTH:0]         m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready
);

    localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t               state;
    logic                 grant;
    logic                 last_grant;
    logic [CNT_WIDTH-1:0] outstanding;

    logic aw_hs;
    logic w_last_hs;
    logic b_hs;
    logic any_req;
    logic can_grant;
    logic next_grant;
    logic b_sel;
    logic in_addr;
    logic in_data;

    assign in_addr   = (state == ADDR);
    assign in_data   = (state == DATA);
    assign aw_hs     = m_axi_awvalid & m_axi_awready;
    assign w_last_hs = m_axi_wvalid & m_axi_wready & m_axi_wlast;
    assign b_hs      = m_axi_bvalid & m_axi_bready;
    assign any_req   = s0_axi_awvalid | s1_axi_awvalid;

    // A B handshake in the current cycle frees a slot, so the next burst may be granted right away.
    assign can_grant = (outstanding < CNT_WIDTH'(MAX_OUTSTANDING)) | b_hs;

    // Round-robin pick: on a tie the requester not granted last wins.
    assign next_grant = (s0_axi_awvalid & s1_axi_awvalid) ? ~last_grant : s1_axi_awvalid;

    // Burst-level FSM: grant in IDLE, pass AW in ADDR, pass W beats in DATA until wlast.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req && can_grant) begin
                        grant      <= next_grant;
                        last_grant <= next_grant;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (aw_hs) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (w_last_hs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bursts issued to DDR but not yet answered; saturating at both ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else if (aw_hs && !b_hs) begin
            if (outstanding != CNT_WIDTH'(MAX_OUTSTANDING)) begin
                outstanding <= outstanding + CNT_WIDTH'(1);
            end
        end else if (b_hs && !aw_hs) begin
            if (outstanding != '0) begin
                outstanding <= outstanding - CNT_WIDTH'(1);
            end
        end
    end

    // AW mux: granted requester's fields, ID extended with the grant bit.
    assign m_axi_awid     = {grant, grant ? s1_axi_awid : s0_axi_awid};
    assign m_axi_awaddr   = grant ? s1_axi_awaddr  : s0_axi_awaddr;
    assign m_axi_awlen    = grant ? s1_axi_awlen   : s0_axi_awlen;
    assign m_axi_awsize   = grant ? s1_axi_awsize  : s0_axi_awsize;
    assign m_axi_awburst  = grant ? s1_axi_awburst : s0_axi_awburst;
    assign m_axi_awvalid  = in_addr & (grant ? s1_axi_awvalid : s0_axi_awvalid);
    assign s0_axi_awready = in_addr & ~grant & m_axi_awready;
    assign s1_axi_awready = in_addr &  grant & m_axi_awready;

    // W mux: only the granted requester sees wready, and only during DATA.
    assign m_axi_wdata    = grant ? s1_axi_wdata : s0_axi_wdata;
    assign m_axi_wstrb    = grant ? s1_axi_wstrb : s0_axi_wstrb;
    assign m_axi_wlast    = grant ? s1_axi_wlast : s0_axi_wlast;
    assign m_axi_wvalid   = in_data & (grant ? s1_axi_wvalid : s0_axi_wvalid);
    assign s0_axi_wready  = in_data & ~grant & m_axi_wready;
    assign s1_axi_wready  = in_data &  grant & m_axi_wready;

    // B demux: independent of FSM state, steered by the ID MSB.
    assign b_sel          = m_axi_bid[ID_WIDTH];
    assign s0_axi_bid     = m_axi_bid[ID_WIDTH-1:0];
    assign s1_axi_bid     = m_axi_bid[ID_WIDTH-1:0];
    assign s0_axi_bresp   = m_axi_bresp;
    assign s1_axi_bresp   = m_axi_bresp;
    assign s0_axi_bvalid  = m_axi_bvalid & ~b_sel;
    assign s1_axi_bvalid  = m_axi_bvalid &  b_sel;
    assign m_axi_bready   = b_sel ? s1_axi_bready : s0_axi_bready;

endmodule

// File: tb/tb_mrmac_ddr_wr_arb.sv
// Directed bench for mrmac_ddr_wr_arb with a scripted DDR-side responder.
module tb_mrmac_ddr_wr_arb;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned IW = 4;
    localparam int unsigned MO = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [IW-1:0] s_awid    [2];
    logic [AW-1:0] s_awaddr  [2];
    logic [7:0]    s_awlen   [2];
    logic [2:0]    s_awsize  [2];
    logic [1:0]    s_awburst [2];
    logic          s_awvalid [2];
    logic          s_awready [2];
    logic [DW-1:0] s_wdata   [2];
    logic [SW-1:0] s_wstrb   [2];
    logic          s_wlast   [2];
    logic          s_wvalid  [2];
    logic          s_wready  [2];
    logic [IW-1:0] s_bid     [2];
    logic [1:0]    s_bresp   [2];
    logic          s_bvalid  [2];
    logic          s_bready  [2];

    logic [IW:0]   m_awid;
    logic [AW-1:0] m_awaddr;
    logic [7:0]    m_awlen;
    logic [2:0]    m_awsize;
    logic [1:0]    m_awburst;
    logic          m_awvalid;
    logic          m_awready;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    logic          m_wlast;
    logic          m_wvalid;
    logic          m_wready;
    logic          m_wready_fix;
    logic          wr_toggle;
    logic [IW:0]   m_bid;
    logic [1:0]    m_bresp;
    logic          m_bvalid;
    logic          m_bready;

    assign m_wready = wr_toggle ? cyc[0] : m_wready_fix;

    mrmac_ddr_wr_arb #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst),
        .s0_axi_awid(s_awid[0]), .s0_axi_awaddr(s_awaddr[0]), .s0_axi_awlen(s_awlen[0]),
        .s0_axi_awsize(s_awsize[0]), .s0_axi_awburst(s_awburst[0]),
        .s0_axi_awvalid(s_awvalid[0]), .s0_axi_awready(s_awready[0]),
        .s0_axi_wdata(s_wdata[0]), .s0_axi_wstrb(s_wstrb[0]), .s0_axi_wlast(s_wlast[0]),
        .s0_axi_wvalid(s_wvalid[0]), .s0_axi_wready(s_wready[0]),
        .s0_axi_bid(s_bid[0]), .s0_axi_bresp(s_bresp[0]),
        .s0_axi_bvalid(s_bvalid[0]), .s0_axi_bready(s_bready[0]),
        .s1_axi_awid(s_awid[1]), .s1_axi_awaddr(s_awaddr[1]), .s1_axi_awlen(s_awlen[1]),
        .s1_axi_awsize(s_awsize[1]), .s1_axi_awburst(s_awburst[1]),
        .s1_axi_awvalid(s_awvalid[1]), .s1_axi_awready(s_awready[1]),
        .s1_axi_wdata(s_wdata[1]), .s1_axi_wstrb(s_wstrb[1]), .s1_axi_wlast(s_wlast[1]),
        .s1_axi_wvalid(s_wvalid[1]), .s1_axi_wready(s_wready[1]),
        .s1_axi_bid(s_bid[1]), .s1_axi_bresp(s_bresp[1]),
        .s1_axi_bvalid(s_bvalid[1]), .s1_axi_bready(s_bready[1]),
        .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen),
        .m_axi_awsize(m_awsize), .m_axi_awburst(m_awburst),
        .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
        .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast),
        .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
        .m_axi_bid(m_bid), .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid),
        .m_axi_bready(m_bready)
    );

    typedef struct { logic [IW:0] id; logic [AW-1:0] addr; logic [7:0] len; int cyc; } aw_rec_t;
    typedef struct { logic [DW-1:0] data; logic last; int cyc; } w_rec_t;
    typedef struct { int r; logic [IW-1:0] id; logic [1:0] resp; int cyc; } b_rec_t;

    aw_rec_t aw_q[$];
    w_rec_t  w_q[$];
    b_rec_t  b_q[$];

    // Handshake log, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_awvalid && m_awready) aw_q.push_back('{m_awid, m_awaddr, m_awlen, cyc});
            if (m_wvalid && m_wready)   w_q.push_back('{m_wdata, m_wlast, cyc});
            for (int r = 0; r < 2; r++) begin
                if (s_bvalid[r] && s_bready[r]) b_q.push_back('{r, s_bid[r], s_bresp[r], cyc});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, need finish earlier", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        aw_q.delete();
        w_q.delete();
        b_q.delete();
    endtask

    // One requester burst: AW handshake, then `beats` W beats with data base+i.
    task automatic burst(input int r, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input int beats, input logic [DW-1:0] base);
        int n;
        s_awid[r] = id; s_awaddr[r] = addr; s_awlen[r] = 8'(beats - 1);
        s_awsize[r] = 3'd3; s_awburst[r] = 2'b01; s_awvalid[r] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_awready[r] && n < 300);
        checks++;
        if (!s_awready[r]) begin
            errors++;
            $display("FAIL aw_wait r=%0d id=%h: awready=%b, need 1 within 300 cycles", r, id, s_awready[r]);
        end
        tick();
        s_awvalid[r] = 1'b0;
        for (int i = 0; i < beats; i++) begin
            s_wdata[r] = base + DW'(i); s_wstrb[r] = '1;
            s_wlast[r] = (i == beats - 1); s_wvalid[r] = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!s_wready[r] && n < 300);
            if (!s_wready[r]) begin
                checks++; errors++;
                $display("FAIL w_wait r=%0d beat=%0d: wready=%b, need 1 within 300 cycles", r, i, s_wready[r]);
                break;
            end
            tick();
        end
        s_wvalid[r] = 1'b0;
        s_wlast[r]  = 1'b0;
    endtask

    // DDR responder: present one B beat and hold it until accepted.
    task automatic send_b(input logic [IW:0] id, input logic [1:0] resp);
        int n;
        m_bid = id; m_bresp = resp; m_bvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!m_bready && n < 100);
        checks++;
        if (!m_bready) begin
            errors++;
            $display("FAIL b_wait id=%h: m_bready=%b, need 1 within 100 cycles", id, m_bready);
        end
        tick();
        m_bvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_wvalid[0] = 1'b1; s_wvalid[1] = 1'b1;
        repeat (3) @(posedge clk);
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 1) begin
                tick();
                rst = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (m_awvalid !== 1'b0) begin errors++; $display("FAIL reset_m_awvalid ph=%0d: got %b need 0", ph, m_awvalid); end
            checks++;
            if (m_wvalid !== 1'b0) begin errors++; $display("FAIL reset_m_wvalid ph=%0d: got %b need 0", ph, m_wvalid); end
            checks++;
            if ({s_awready[0], s_awready[1]} !== 2'b00) begin
                errors++; $display("FAIL reset_awready ph=%0d: got %b%b need 00", ph, s_awready[0], s_awready[1]);
            end
            checks++;
            if ({s_wready[0], s_wready[1]} !== 2'b00) begin
                errors++; $display("FAIL reset_wready ph=%0d: got %b%b need 00", ph, s_wready[0], s_wready[1]);
            end
        end
        s_wvalid[0] = 1'b0; s_wvalid[1] = 1'b0;
    endtask

    task automatic test_single();
        tick();
        clear_logs();
        burst(0, 4'h5, 32'h0000_1000, 7, 64'h100);
        checks++;
        if (aw_q.size() != 1) begin errors++; $display("FAIL single_aw_count: got %0d need 1", aw_q.size()); end
        else begin
            checks++;
            if (aw_q[0].id !== 5'h05) begin errors++; $display("FAIL single_awid: got %h need 05", aw_q[0].id); end
            checks++;
            if (aw_q[0].len !== 8'd6 || aw_q[0].addr !== 32'h0000_1000) begin
                errors++; $display("FAIL single_aw_fields: len=%0d addr=%h need 6 00001000", aw_q[0].len, aw_q[0].addr);
            end
        end
        checks++;
        if (w_q.size() != 7) begin errors++; $display("FAIL single_w_count: got %0d need 7", w_q.size()); end
        else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (w_q[i].data !== 64'h100 + 64'(i) || w_q[i].last !== (i == 6)) begin
                    errors++;
                    $display("FAIL single_beat%0d: data=%h last=%b need %h %b", i, w_q[i].data, w_q[i].last, 64'h100 + 64'(i), i == 6);
                end
            end
        end
        send_b(5'h05, 2'b00);
        checks++;
        if (b_q.size() != 1 || b_q[0].r != 0 || b_q[0].id !== 4'h5 || b_q[0].resp !== 2'b00) begin
            errors++;
            $display("FAIL single_b: count=%0d r=%0d id=%h resp=%b need 1 0 5 00",
                     b_q.size(), (b_q.size() > 0) ? b_q[0].r : -1, (b_q.size() > 0) ? b_q[0].id : 4'hx,
                     (b_q.size() > 0) ? b_q[0].resp : 2'bxx);
        end
    endtask

    task automatic test_contention();
        logic [DW-1:0] exp;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        clear_logs();
        fork
            burst(0, 4'h1, 32'h0000_2000, 4, 64'hA00);
            burst(1, 4'h2, 32'h0000_3000, 3, 64'hB00);
        join
        checks++;
        if (aw_q.size() != 2) begin errors++; $display("FAIL cont_aw_count: got %0d need 2", aw_q.size()); end
        else begin
            checks++;
            if (aw_q[0].id !== 5'h01) begin errors++; $display("FAIL cont_first_awid: got %h need 01", aw_q[0].id); end
            checks++;
            if (aw_q[1].id !== 5'h12) begin errors++; $display("FAIL cont_second_awid: got %h need 12", aw_q[1].id); end
        end
        checks++;
        if (w_q.size() != 7) begin errors++; $display("FAIL cont_w_count: got %0d need 7", w_q.size()); end
        else begin
            for (int i = 0; i < 7; i++) begin
                exp = (i < 4) ? 64'hA00 + 64'(i) : 64'hB00 + 64'(i - 4);
                checks++;
                if (w_q[i].data !== exp || w_q[i].last !== (i == 3 || i == 6)) begin
                    errors++;
                    $display("FAIL cont_beat%0d: data=%h last=%b need %h %b", i, w_q[i].data, w_q[i].last, exp, i == 3 || i == 6);
                end
            end
        end
    endtask

    task automatic test_out_of_order();
        b_q.delete();
        send_b(5'h12, 2'b10);
        send_b(5'h01, 2'b00);
        checks++;
        if (b_q.size() != 2) begin errors++; $display("FAIL ooo_b_count: got %0d need 2", b_q.size()); end
        else begin
            checks++;
            if (b_q[0].r != 1 || b_q[0].id !== 4'h2 || b_q[0].resp !== 2'b10) begin
                errors++; $display("FAIL ooo_first: r=%0d id=%h resp=%b need 1 2 10", b_q[0].r, b_q[0].id, b_q[0].resp);
            end
            checks++;
            if (b_q[1].r != 0 || b_q[1].id !== 4'h1 || b_q[1].resp !== 2'b00) begin
                errors++; $display("FAIL ooo_second: r=%0d id=%h resp=%b need 0 1 00", b_q[1].r, b_q[1].id, b_q[1].resp);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_logs();
        wr_toggle = 1'b1;
        fork
            burst(1, 4'h7, 32'h0000_4000, 13, 64'hC00);
            begin
                repeat (3) tick();
                burst(0, 4'h3, 32'h0000_5000, 1, 64'hD00);
            end
        join
        wr_toggle = 1'b0;
        checks++;
        if (w_q.size() != 14) begin errors++; $display("FAIL bp_w_count: got %0d need 14", w_q.size()); end
        else begin
            for (int i = 0; i < 13; i++) begin
                checks++;
                if (w_q[i].data !== 64'hC00 + 64'(i) || w_q[i].last !== (i == 12)) begin
                    errors++;
                    $display("FAIL bp_beat%0d: data=%h last=%b need %h %b", i, w_q[i].data, w_q[i].last, 64'hC00 + 64'(i), i == 12);
                end
            end
        end
        checks++;
        if (aw_q.size() != 2) begin errors++; $display("FAIL bp_aw_count: got %0d need 2", aw_q.size()); end
        else if (w_q.size() == 14) begin
            checks++;
            if (aw_q[1].id !== 5'h03 || aw_q[1].cyc != w_q[12].cyc + 2) begin
                errors++;
                $display("FAIL bp_idle_gap: awid=%h aw_cyc=%0d need 03 at %0d", aw_q[1].id, aw_q[1].cyc, w_q[12].cyc + 2);
            end
        end
        send_b(5'h17, 2'b00);
        send_b(5'h03, 2'b00);
    endtask

    task automatic test_outstanding_limit();
        int bcyc;
        clear_logs();
        bcyc = -100;
        burst(0, 4'h8, 32'h0000_6000, 1, 64'hE00);
        burst(0, 4'h9, 32'h0000_6100, 1, 64'hE10);
        fork
            burst(0, 4'hA, 32'h0000_6200, 1, 64'hE20);
            begin
                repeat (10) tick();
                checks++;
                if (aw_q.size() != 2) begin errors++; $display("FAIL limit_blocked: aw count %0d need 2", aw_q.size()); end
                send_b(5'h08, 2'b00);
                if (b_q.size() > 0) bcyc = b_q[b_q.size() - 1].cyc;
            end
        join
        checks++;
        if (aw_q.size() != 3 || aw_q[aw_q.size() - 1].cyc != bcyc + 1) begin
            errors++;
            $display("FAIL limit_release: aw count %0d last_cyc=%0d need 3 at %0d",
                     aw_q.size(), (aw_q.size() > 0) ? aw_q[aw_q.size() - 1].cyc : -1, bcyc + 1);
        end
        send_b(5'h09, 2'b00);
        send_b(5'h0A, 2'b00);
    endtask

    task automatic test_simultaneous();
        int n;
        clear_logs();
        burst(0, 4'h4, 32'h0000_7000, 1, 64'hF00);
        m_awready = 1'b0;
        fork
            burst(0, 4'h5, 32'h0000_7100, 1, 64'hF10);
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (!m_awvalid && n < 50);
                tick();
                m_awready = 1'b1;
                m_bid = 5'h04; m_bresp = 2'b00; m_bvalid = 1'b1;
                tick();
                m_bvalid = 1'b0;
            end
        join
        checks++;
        if (aw_q.size() != 2 || b_q.size() != 1 || aw_q[aw_q.size() - 1].cyc != b_q[0].cyc) begin
            errors++;
            $display("FAIL sim_same_cycle: aw=%0d b=%0d aw_cyc=%0d b_cyc=%0d need 2 1 equal",
                     aw_q.size(), b_q.size(), (aw_q.size() > 0) ? aw_q[aw_q.size() - 1].cyc : -1,
                     (b_q.size() > 0) ? b_q[0].cyc : -2);
        end
        burst(0, 4'h6, 32'h0000_7200, 1, 64'hF20);
        checks++;
        if (aw_q.size() != 3) begin errors++; $display("FAIL sim_slot_free: aw count %0d need 3", aw_q.size()); end
        fork
            burst(0, 4'h7, 32'h0000_7300, 1, 64'hF30);
            begin
                repeat (10) tick();
                checks++;
                if (aw_q.size() != 3) begin errors++; $display("FAIL sim_limit_held: aw count %0d need 3", aw_q.size()); end
                send_b(5'h05, 2'b00);
            end
        join
        send_b(5'h06, 2'b00);
        send_b(5'h07, 2'b00);
    endtask

    initial begin
        rst = 1'b1;
        for (int r = 0; r < 2; r++) begin
            s_awid[r] = '0; s_awaddr[r] = '0; s_awlen[r] = '0; s_awsize[r] = '0;
            s_awburst[r] = '0; s_awvalid[r] = 1'b0;
            s_wdata[r] = '0; s_wstrb[r] = '0; s_wlast[r] = 1'b0; s_wvalid[r] = 1'b0;
            s_bready[r] = 1'b1;
        end
        m_awready = 1'b1; m_wready_fix = 1'b1; wr_toggle = 1'b0;
        m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;

        test_reset();
        test_single();
        test_contention();
        test_out_of_order();
        test_backpressure();
        test_outstanding_limit();
        test_simultaneous();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
